// File: rtl/dac_sample_sequencer_if.sv
// Upstream/serializer-facing signal bundle for the DAC sample sequencer.
// The DUT connects through the slave modport; the producer/serializer side uses master.
interface dac_sample_sequencer_if #(
  parameter int DEPTH = 16
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             en;
  logic             clr_flags;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic [7:0]       gap_cfg;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic             start_sig;
  logic [7:0]       din;
  logic             done_sig;
  logic             busy;
  logic             timeout_err;
  logic             underrun;

  modport slave (
    input  en, clr_flags, wr_en, wr_data, gap_cfg, done_sig,
    output full, empty, level, start_sig, din, busy, timeout_err, underrun
  );

  modport master (
    output en, clr_flags, wr_en, wr_data, gap_cfg, done_sig,
    input  full, empty, level, start_sig, din, busy, timeout_err, underrun
  );
endinterface

// File: rtl/dac_sample_sequencer.sv
// Sample FIFO feeding a DAC serializer: one start pulse per sample, waits for done
// with a timeout watchdog, then inserts a configurable idle gap before the next sample.
module dac_sample_sequencer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dac_sample_sequencer_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    GAP
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_full;
  logic          r_empty;
  logic [7:0]    r_din;
  logic          r_start_sig;
  logic          r_timeout_err;
  logic          r_underrun;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_gap_cnt;

  logic          w_push;
  logic          w_pop;
  logic          w_to_idle;
  logic          w_set_underrun;
  logic [LW-1:0] w_level_next;

  assign w_push = bus.wr_en && !r_full;
  assign w_pop  = (r_state == IDLE) && bus.en && !r_empty;

  // Every way back to IDLE from an active state: done with no gap, timeout, or gap expiry.
  assign w_to_idle = ((r_state == WAIT_DONE) &&
                      ((bus.done_sig && (bus.gap_cfg == 8'd0)) ||
                       (!bus.done_sig && (r_cnt == CW'(TIMEOUT))))) ||
                     ((r_state == GAP) && (r_gap_cnt == 8'd1));
  assign w_set_underrun = w_to_idle && bus.en && r_empty;

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LW'(1);
      2'b01:   w_level_next = r_level - LW'(1);
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level <= w_level_next;
      r_full  <= (w_level_next == LW'(DEPTH));
      r_empty <= (w_level_next == LW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_din         <= 8'd0;
      r_start_sig   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_underrun    <= 1'b0;
      r_cnt         <= '0;
      r_gap_cnt     <= 8'd0;
    end else begin
      r_start_sig   <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_din       <= r_mem[r_rd_ptr];
            r_start_sig <= 1'b1;
            r_cnt       <= CW'(1);
            r_state     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // r_cnt is 1 in the start cycle, so a done seen while r_cnt==TIMEOUT still succeeds.
          if (bus.done_sig) begin
            if (bus.gap_cfg != 8'd0) begin
              r_gap_cnt <= bus.gap_cfg;
              r_state   <= GAP;
            end else begin
              r_state <= IDLE;
            end
          end else if (r_cnt == CW'(TIMEOUT)) begin
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        GAP: begin
          if (r_gap_cnt == 8'd1) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_set_underrun) begin
        r_underrun <= 1'b1;
      end else if (bus.clr_flags) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign bus.full        = r_full;
  assign bus.empty       = r_empty;
  assign bus.level       = r_level;
  assign bus.start_sig   = r_start_sig;
  assign bus.din         = r_din;
  assign bus.busy        = (r_state != IDLE);
  assign bus.timeout_err = r_timeout_err;
  assign bus.underrun    = r_underrun;
endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Scoreboarded bench: pushes queue expected din values, a monitor pops them on each
// start_sig, and a serializer model answers starts with done after a programmable delay.
module tb_dac_sample_sequencer;
  logic clk;
  logic rst_n;

  dac_sample_sequencer_if #(.DEPTH(16)) sif ();

  dac_sample_sequencer #(.DEPTH(16), .TIMEOUT(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_starts = 0;
  int         n_tmo = 0;
  int         n_busy = 0;
  int         cyc = 0;
  int         tmo_cyc = -1;
  int         ser_lat = -1;
  logic [7:0] exp_q[$];
  int         start_cycs[$];
  int         done_cycs[$];

  // Serializer: done_sig is high during the cycle ser_lat cycles after the start cycle; -1 = never.
  initial begin : serializer
    bit pend;
    int due;
    pend = 1'b0;
    due = 0;
    sif.done_sig = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      sif.done_sig = 1'b0;
      if (sif.start_sig === 1'b1) begin
        pend = (ser_lat >= 0);
        due = cyc + ser_lat;
      end
      if (pend && cyc == due) begin
        sif.done_sig = 1'b1;
        pend = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (sif.start_sig === 1'b1) begin
        n_starts++;
        start_cycs.push_back(cyc);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_start: din=%02h with no sample outstanding (cyc %0d)", sif.din, cyc);
        end else begin
          e = exp_q.pop_front();
          if (sif.din !== e) begin
            n_bad++;
            $display("FAIL din_order: got %02h expected %02h (cyc %0d)", sif.din, e, cyc);
          end else begin
            $display("start cyc=%0d din=%02h", cyc, sif.din);
          end
        end
      end
      if (sif.timeout_err === 1'b1) begin
        n_tmo++;
        tmo_cyc = cyc;
      end
      if (sif.done_sig === 1'b1) done_cycs.push_back(cyc);
      if (sif.busy === 1'b1) n_busy++;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit accept);
    sif.wr_en = 1'b1;
    sif.wr_data = d;
    tick();
    sif.wr_en = 1'b0;
    if (accept) exp_q.push_back(d);
  endtask

  task automatic pulse_clr();
    sif.clr_flags = 1'b1;
    tick();
    sif.clr_flags = 1'b0;
  endtask

  task automatic wait_idle(input int target, input int limit, output bit ok);
    int i;
    i = 0;
    while (!(n_starts >= target && sif.busy === 1'b0) && i < limit) begin
      tick();
      i++;
    end
    ok = (n_starts >= target && sif.busy === 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (sif.level !== 5'd0) begin n_bad++; $display("FAIL reset_level: got %0d expected 0", sif.level); end
    n_cmp++; if (sif.empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b expected 1", sif.empty); end
    n_cmp++; if (sif.full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b expected 0", sif.full); end
    n_cmp++; if (sif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", sif.busy); end
    n_cmp++; if (sif.din !== 8'h00) begin n_bad++; $display("FAIL reset_din: got %02h expected 00", sif.din); end
    n_cmp++; if (sif.start_sig !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b expected 0", sif.start_sig); end
    n_cmp++; if (sif.timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_tmo: got %b expected 0", sif.timeout_err); end
    n_cmp++; if (sif.underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b expected 0", sif.underrun); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int s0;
    bit ok;
    sif.gap_cfg = 8'd0;
    ser_lat = 16;
    push(8'h5A, 1'b1);
    s0 = n_starts;
    n_busy = 0;
    sif.en = 1'b1;
    wait_idle(s0 + 1, 200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_wait: got no completion expected idle within 200 cycles"); end
    n_cmp++; if (n_starts - s0 != 1) begin n_bad++; $display("FAIL single_starts: got %0d expected 1", n_starts - s0); end
    n_cmp++; if (n_busy != 17) begin n_bad++; $display("FAIL single_busy: got %0d cycles expected 17", n_busy); end
    n_cmp++; if (sif.empty !== 1'b1) begin n_bad++; $display("FAIL single_empty: got %b expected 1", sif.empty); end
    n_cmp++; if (sif.underrun !== 1'b1) begin n_bad++; $display("FAIL single_underrun: got %b expected 1", sif.underrun); end
    $display("test_single done busy=%0d", n_busy);
  endtask

  task automatic test_clr_underrun();
    pulse_clr();
    n_cmp++; if (sif.underrun !== 1'b0) begin n_bad++; $display("FAIL clr_underrun: got %b expected 0", sif.underrun); end
    sif.en = 1'b0;
    $display("test_clr_underrun done");
  endtask

  task automatic test_fill();
    int s0;
    bit ok;
    sif.en = 1'b0;
    for (int i = 0; i < 17; i++) push(8'(8'h30 + i * 7), i < 16);
    n_cmp++; if (sif.level !== 5'd16) begin n_bad++; $display("FAIL fill_level: got %0d expected 16", sif.level); end
    n_cmp++; if (sif.full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b expected 1", sif.full); end
    n_cmp++; if (sif.empty !== 1'b0) begin n_bad++; $display("FAIL fill_empty: got %b expected 0", sif.empty); end
    ser_lat = 3;
    s0 = n_starts;
    sif.en = 1'b1;
    wait_idle(s0 + 16, 600, ok);
    repeat (10) tick();
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL fill_wait: got no completion expected 16 transfers within 600 cycles"); end
    n_cmp++; if (n_starts - s0 != 16) begin n_bad++; $display("FAIL fill_starts: got %0d expected 16", n_starts - s0); end
    n_cmp++; if (sif.level !== 5'd0) begin n_bad++; $display("FAIL fill_drain_level: got %0d expected 0", sif.level); end
    sif.en = 1'b0;
    pulse_clr();
    $display("test_fill done");
  endtask

  task automatic test_gap();
    int s0;
    bit ok;
    sif.gap_cfg = 8'd4;
    ser_lat = 2;
    start_cycs.delete();
    done_cycs.delete();
    push(8'hA1, 1'b1);
    push(8'hB2, 1'b1);
    s0 = n_starts;
    sif.en = 1'b1;
    wait_idle(s0 + 2, 200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL gap_wait: got no completion expected idle within 200 cycles"); end
    n_cmp++;
    if (start_cycs.size() < 2 || done_cycs.size() < 1) begin
      n_bad++;
      $display("FAIL gap_events: got %0d starts %0d dones expected 2 and >=1", start_cycs.size(), done_cycs.size());
    end else begin
      // Done sampled at the edge ending cycle d; 4 GAP cycles + 1 IDLE cycle later start rises in cycle d+6.
      if (start_cycs[1] - done_cycs[0] != 6) begin
        n_bad++;
        $display("FAIL gap_done_to_start: got %0d expected 6", start_cycs[1] - done_cycs[0]);
      end
      n_cmp++;
      if (start_cycs[1] - start_cycs[0] != 8) begin
        n_bad++;
        $display("FAIL gap_start_spacing: got %0d expected 8", start_cycs[1] - start_cycs[0]);
      end
    end
    sif.en = 1'b0;
    sif.gap_cfg = 8'd0;
    pulse_clr();
    $display("test_gap done");
  endtask

  task automatic test_timeout();
    int s0;
    int t0;
    int i;
    bit ok;
    ser_lat = -1;
    start_cycs.delete();
    t0 = n_tmo;
    push(8'hC3, 1'b1);
    push(8'hD4, 1'b1);
    s0 = n_starts;
    sif.en = 1'b1;
    i = 0;
    while (n_starts < s0 + 1 && i < 20) begin
      tick();
      i++;
    end
    ser_lat = 5;
    wait_idle(s0 + 2, 200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_wait: got no completion expected idle within 200 cycles"); end
    n_cmp++; if (n_tmo - t0 != 1) begin n_bad++; $display("FAIL tmo_pulses: got %0d expected 1", n_tmo - t0); end
    n_cmp++;
    if (start_cycs.size() < 2) begin
      n_bad++;
      $display("FAIL tmo_starts: got %0d expected 2", start_cycs.size());
    end else begin
      if (tmo_cyc - start_cycs[0] != 32) begin
        n_bad++;
        $display("FAIL tmo_delay: got %0d expected 32", tmo_cyc - start_cycs[0]);
      end
      n_cmp++;
      if (start_cycs[1] - tmo_cyc != 1) begin
        n_bad++;
        $display("FAIL tmo_next_start: got %0d expected 1", start_cycs[1] - tmo_cyc);
      end
    end
    sif.en = 1'b0;
    pulse_clr();
    $display("test_timeout done");
  endtask

  task automatic test_done_at_limit();
    int s0;
    int t0;
    bit ok;
    ser_lat = 31;
    t0 = n_tmo;
    push(8'hE5, 1'b1);
    s0 = n_starts;
    n_busy = 0;
    sif.en = 1'b1;
    wait_idle(s0 + 1, 200, ok);
    repeat (3) tick();
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL limit_wait: got no completion expected idle within 200 cycles"); end
    n_cmp++; if (n_tmo != t0) begin n_bad++; $display("FAIL limit_tmo: got %0d pulses expected 0", n_tmo - t0); end
    n_cmp++; if (n_busy != 32) begin n_bad++; $display("FAIL limit_busy: got %0d cycles expected 32", n_busy); end
    sif.en = 1'b0;
    pulse_clr();
    $display("test_done_at_limit done");
  endtask

  task automatic test_reset_mid();
    int s0;
    int s1;
    int i;
    ser_lat = -1;
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    push(8'h44, 1'b1);
    s0 = n_starts;
    sif.en = 1'b1;
    i = 0;
    while (n_starts < s0 + 1 && i < 20) begin
      tick();
      i++;
    end
    repeat (2) tick();
    n_cmp++; if (sif.level !== 5'd3) begin n_bad++; $display("FAIL mid_level_before: got %0d expected 3", sif.level); end
    n_cmp++; if (sif.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b expected 1", sif.busy); end
    rst_n = 1'b0;
    repeat (2) tick();
    exp_q.delete();
    s1 = n_starts;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (sif.level !== 5'd0) begin n_bad++; $display("FAIL mid_level_after: got %0d expected 0", sif.level); end
    n_cmp++; if (sif.busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy_after: got %b expected 0", sif.busy); end
    n_cmp++; if (sif.underrun !== 1'b0) begin n_bad++; $display("FAIL mid_underrun_after: got %b expected 0", sif.underrun); end
    repeat (6) tick();
    n_cmp++; if (n_starts != s1) begin n_bad++; $display("FAIL mid_no_start: got %0d starts expected 0", n_starts - s1); end
    sif.en = 1'b0;
    $display("test_reset_mid done");
  endtask

  initial begin
    rst_n = 1'b0;
    sif.en = 1'b0;
    sif.clr_flags = 1'b0;
    sif.wr_en = 1'b0;
    sif.wr_data = 8'h00;
    sif.gap_cfg = 8'h00;
    test_reset();
    test_single();
    test_clr_underrun();
    test_fill();
    test_gap();
    test_timeout();
    test_done_at_limit();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
